mult_accuracy_sweeper: RTL and testbench
========================================

// Module: mult_accuracy_sweeper
// PURPOSE
//   On-chip accuracy controller for one approximate recursive multiplier (e.g. an M8_x instance).
//   Drives every operand pair (a,b) in 0..2^W-1 through the external multiplier.
//   Checks each returned product against the exact a*b.
//   Reports match count, error count and max error distance: the hardware version of our exhaustive benches.
// PARAMETERS
//   W         8   operand width; sweep length 2^(2W) pairs
//   PIPE_LAT  0   multiplier latency in clk cycles (0 = combinational DUT)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      begin sweep (sampled in IDLE or DONE)
//   abort      in   1      stop an in-progress sweep
//   busy       out  1      high in SWEEP
//   done       out  1      high in DONE; results valid
//   mult_a     out  W      operand a to multiplier (registered)
//   mult_b     out  W      operand b to multiplier (registered)
//   mult_y     in   2W     multiplier product, PIPE_LAT cycles after mult_a/mult_b
//   match_cnt  out  2W+1   pairs with mult_y == a*b
//   err_cnt    out  2W+1   pairs with mult_y != a*b
//   max_err    out  2W     max |mult_y - a*b| seen
// BEHAVIOUR
//   - Reset: state IDLE; busy=0, done=0, mult_a=0, mult_b=0, all counters 0.
//   - FSM IDLE -start-> SWEEP -last compare-> DONE -start-> SWEEP.
//     abort in SWEEP -> IDLE with counters cleared.
//     start while in SWEEP is ignored.
//   - Entering SWEEP: counters cleared; operand issue begins the same cycle.
//   - Issue order: a outer, b inner (a=0,b=0..2^W-1; a=1,...). One pair per cycle.
//     mult_a/mult_b hold after the final pair (2^W-1, 2^W-1).
//   - Compare: exact product from the issued operands, delayed PIPE_LAT cycles, vs mult_y.
//     Compare is enabled by a PIPE_LAT-deep valid shift register.
//   - Sweep time: exactly 2^(2W)+PIPE_LAT cycles from entering SWEEP to entering DONE.
//   - Invariant: match_cnt+err_cnt == 2^(2W) in DONE.
//   - Counters are 2W+1 bits so 2^(2W) is representable: no wrap.
//   - max_err is an unsigned magnitude, updated only when strictly greater.
//   - done is a level: held with results stable until the next start or rst.
//   - rst mid-sweep: immediate return to reset values; no partial results retained.
// CONFIGURATION
//   MULT_SWEEP_MED_EN defined:
//     adds output sum_err [4W+1] = Σ|mult_y - a*b|, cleared on SWEEP entry.
//     Mean error distance = sum_err / 2^(2W), computed off-chip.
//   Undefined: no sum_err port or accumulator.
// STRUCTURE
//   Package mult_sweep_pkg:
//     state enum {IDLE, SWEEP, DONE}
//     width helpers CNT_W = 2W+1, SUM_W = 4W+1
//   Sub-module sweep_delay_line (PIPE_LAT-deep delay of {valid, a, b});
//     a PIPE_LAT=0 instance is a pass-through.
//   The multiplier under test is instantiated outside, by the integrating top.
// TESTING
//   1. W=8, PIPE_LAT=0, exact stub mult_y=a*b, pulse start
//      -> done after 65536 cycles; match_cnt=65536, err_cnt=0, max_err=0.
//   2. W=8, stub mult_y=(a*b)&~1 -> match_cnt=49152, err_cnt=16384, max_err=1.
//   3. W=4, stub mult_y=0 -> match_cnt=31, err_cnt=225, max_err=225;
//      with MULT_SWEEP_MED_EN, sum_err=14400.
//   4. W=8, PIPE_LAT=2, 2-stage registered exact stub
//      -> match_cnt=65536, done at cycle 65538; start pulses mid-sweep ignored.
//   5. rst at cycle 1000 of sweep -> all outputs 0 next edge;
//      new start -> full 65536-pair sweep.
//   6. abort at cycle 500 -> IDLE, counters 0, done=0;
//      start from DONE re-runs and reproduces identical results.

Source files
------------

// File: rtl/mult_sweep_pkg.sv
// Shared types and width helpers for the multiplier accuracy sweeper.
package mult_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    // CNT_W: counters must hold 2^(2W) without wrapping.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    // SUM_W: worst-case sum of 2^(2W) error distances, each below 2^(2W).
    function automatic int sum_w(input int w);
        return 4 * w + 1;
    endfunction

endpackage

// File: rtl/sweep_delay_line.sv
// LAT-deep delay of {valid, a, b} aligning issued operands with the multiplier product.
// A LAT=0 instance is a pure pass-through; flush drops in-flight valid bits.
module sweep_delay_line #(
    parameter int W   = 8,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, flush};
            assign out_valid  = in_valid;
            assign out_a      = in_a;
            assign out_b      = in_b;
        end else begin : g_pipe
            logic [LAT-1:0] v_sr;
            logic [W-1:0]   a_sr [LAT];
            logic [W-1:0]   b_sr [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_sr <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        a_sr[i] <= '0;
                        b_sr[i] <= '0;
                    end
                end else begin
                    v_sr[0] <= in_valid && !flush;
                    a_sr[0] <= in_a;
                    b_sr[0] <= in_b;
                    for (int i = 1; i < LAT; i++) begin
                        v_sr[i] <= v_sr[i-1] && !flush;
                        a_sr[i] <= a_sr[i-1];
                        b_sr[i] <= b_sr[i-1];
                    end
                end
            end

            assign out_valid = v_sr[LAT-1];
            assign out_a     = a_sr[LAT-1];
            assign out_b     = b_sr[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mult_accuracy_sweeper.sv
// Exhaustive accuracy sweep of an external multiplier: match/error counts and max error distance.
// Optional MULT_SWEEP_MED_EN adds the sum_err accumulator for mean error distance.
module mult_accuracy_sweeper
    import mult_sweep_pkg::*;
#(
    parameter int W        = 8,
    parameter int PIPE_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          mult_a,
    output logic [W-1:0]          mult_b,
    input  logic [2*W-1:0]        mult_y,
    output logic [cnt_w(W)-1:0]   match_cnt,
    output logic [cnt_w(W)-1:0]   err_cnt,
    output logic [2*W-1:0]        max_err
`ifdef MULT_SWEEP_MED_EN
    ,
    output logic [sum_w(W)-1:0]   sum_err
`endif
);

    // IDLE: waiting for start | SWEEP: issuing and comparing | DONE: results held
    sweep_state_t   state_q, state_d;

    logic [2*W-1:0] pair_q;
    logic           issue_valid;
    logic           cmp_valid;
    logic [W-1:0]   cmp_a, cmp_b;
    logic [2*W-1:0] exact, diff;
    logic           start_sweep, abort_sweep, cmp_en, last_cmp;

    assign start_sweep = start && (state_q != SWEEP);
    assign abort_sweep = abort && (state_q == SWEEP);
    assign cmp_en      = cmp_valid && (state_q == SWEEP);
    assign last_cmp    = cmp_en && (cmp_a == '1) && (cmp_b == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (abort)         state_d = IDLE;
                else if (last_cmp) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = SWEEP;
            end
            default: state_d = IDLE;
        endcase
    end

    // {a,b} counted as one 2W-bit value gives a-outer, b-inner order for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q      <= '0;
            issue_valid <= 1'b0;
        end else if (start_sweep) begin
            pair_q      <= '0;
            issue_valid <= 1'b1;
        end else if (abort_sweep) begin
            pair_q      <= '0;
            issue_valid <= 1'b0;
        end else if (issue_valid) begin
            if (pair_q == '1) issue_valid <= 1'b0;
            else              pair_q      <= pair_q + 1'b1;
        end
    end

    assign mult_a = pair_q[2*W-1:W];
    assign mult_b = pair_q[W-1:0];

    sweep_delay_line #(
        .W   (W),
        .LAT (PIPE_LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (start_sweep || abort_sweep),
        .in_valid  (issue_valid),
        .in_a      (mult_a),
        .in_b      (mult_b),
        .out_valid (cmp_valid),
        .out_a     (cmp_a),
        .out_b     (cmp_b)
    );

    assign exact = {{W{1'b0}}, cmp_a} * {{W{1'b0}}, cmp_b};
    assign diff  = (mult_y >= exact) ? (mult_y - exact) : (exact - mult_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            err_cnt   <= '0;
            max_err   <= '0;
        end else if (start_sweep || abort_sweep) begin
            match_cnt <= '0;
            err_cnt   <= '0;
            max_err   <= '0;
        end else if (cmp_en) begin
            if (diff == '0) match_cnt <= match_cnt + 1'b1;
            else            err_cnt   <= err_cnt + 1'b1;
            if (diff > max_err) max_err <= diff;
        end
    end

`ifdef MULT_SWEEP_MED_EN
    localparam int SUM_W = sum_w(W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              sum_err <= '0;
        else if (start_sweep || abort_sweep)  sum_err <= '0;
        else if (cmp_en)                      sum_err <= sum_err + SUM_W'(diff);
    end
`endif

endmodule

// File: tb/tb_mult_accuracy_sweeper.sv
// Directed bench: five W=4 sweepers with different multiplier stubs and latencies share one start/abort.
module tb_mult_accuracy_sweeper;

    localparam int N = 5;

    typedef struct {
        string name;
        int    lat;
        int    exp_match;
        int    exp_err;
        int    exp_max;
        int    exp_sum;
    } vec_t;

    vec_t vecs [N];

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       bz [N];
    logic       dn [N];
    logic [3:0] ma [N];
    logic [3:0] mb [N];
    logic [7:0] y  [N];
    logic [8:0] mc [N];
    logic [8:0] ec [N];
    logic [7:0] mx [N];
`ifdef MULT_SWEEP_MED_EN
    logic [16:0] se [N];
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Multiplier stubs
    logic [7:0] p3a, p3b, p4;
    assign y[0] = 8'(ma[0]) * 8'(mb[0]);
    assign y[1] = (8'(ma[1]) * 8'(mb[1])) & 8'hFE;
    assign y[2] = 8'd0;
    always @(posedge clk) begin
        p3a <= 8'(ma[3]) * 8'(mb[3]);
        p3b <= p3a;
        p4  <= (ma[4] == 4'hF && mb[4] == 4'hF) ? 8'd0 : 8'(ma[4]) * 8'(mb[4]);
    end
    assign y[3] = p3b;
    assign y[4] = p4;

    mult_accuracy_sweeper #(.W(4), .PIPE_LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(bz[0]), .done(dn[0]),
        .mult_a(ma[0]), .mult_b(mb[0]), .mult_y(y[0]),
`ifdef MULT_SWEEP_MED_EN
        .sum_err(se[0]),
`endif
        .match_cnt(mc[0]), .err_cnt(ec[0]), .max_err(mx[0]));

    mult_accuracy_sweeper #(.W(4), .PIPE_LAT(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(bz[1]), .done(dn[1]),
        .mult_a(ma[1]), .mult_b(mb[1]), .mult_y(y[1]),
`ifdef MULT_SWEEP_MED_EN
        .sum_err(se[1]),
`endif
        .match_cnt(mc[1]), .err_cnt(ec[1]), .max_err(mx[1]));

    mult_accuracy_sweeper #(.W(4), .PIPE_LAT(0)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(bz[2]), .done(dn[2]),
        .mult_a(ma[2]), .mult_b(mb[2]), .mult_y(y[2]),
`ifdef MULT_SWEEP_MED_EN
        .sum_err(se[2]),
`endif
        .match_cnt(mc[2]), .err_cnt(ec[2]), .max_err(mx[2]));

    mult_accuracy_sweeper #(.W(4), .PIPE_LAT(2)) u3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(bz[3]), .done(dn[3]),
        .mult_a(ma[3]), .mult_b(mb[3]), .mult_y(y[3]),
`ifdef MULT_SWEEP_MED_EN
        .sum_err(se[3]),
`endif
        .match_cnt(mc[3]), .err_cnt(ec[3]), .max_err(mx[3]));

    mult_accuracy_sweeper #(.W(4), .PIPE_LAT(1)) u4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(bz[4]), .done(dn[4]),
        .mult_a(ma[4]), .mult_b(mb[4]), .mult_y(y[4]),
`ifdef MULT_SWEEP_MED_EN
        .sum_err(se[4]),
`endif
        .match_cnt(mc[4]), .err_cnt(ec[4]), .max_err(mx[4]));

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "/", vecs[i].name, "/busy"},      int'(bz[i]), 0);
            check({tag, "/", vecs[i].name, "/done"},      int'(dn[i]), 0);
            check({tag, "/", vecs[i].name, "/mult_a"},    int'(ma[i]), 0);
            check({tag, "/", vecs[i].name, "/mult_b"},    int'(mb[i]), 0);
            check({tag, "/", vecs[i].name, "/match_cnt"}, int'(mc[i]), 0);
            check({tag, "/", vecs[i].name, "/err_cnt"},   int'(ec[i]), 0);
            check({tag, "/", vecs[i].name, "/max_err"},   int'(mx[i]), 0);
`ifdef MULT_SWEEP_MED_EN
            check({tag, "/", vecs[i].name, "/sum_err"},   int'(se[i]), 0);
`endif
        end
    endtask

    // Pulse start, track done per instance, then compare against the vector table.
    task automatic run_sweep(input string tag, input bit mid_start);
        int  done_cyc [N];
        bit  all_done;
        for (int i = 0; i < N; i++) done_cyc[i] = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "/first_a"}, int'(ma[0]), 0);
        check({tag, "/first_b"}, int'(mb[0]), 0);
        check({tag, "/busy_on"}, int'(bz[3]), 1);
        check({tag, "/cnt_clr"}, int'(mc[0]), 0);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            start = mid_start && (cyc == 100);
            if (cyc == 17) begin
                check({tag, "/order_a"}, int'(ma[0]), 1);
                check({tag, "/order_b"}, int'(mb[0]), 1);
            end
            if (cyc == 200) check({tag, "/busy_mid"}, int'(bz[0]), 1);
            all_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (dn[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
                if (done_cyc[i] < 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check({tag, "/", vecs[i].name, "/done_cycle"}, done_cyc[i], 256 + vecs[i].lat);
            check({tag, "/", vecs[i].name, "/done"},       int'(dn[i]), 1);
            check({tag, "/", vecs[i].name, "/busy"},       int'(bz[i]), 0);
            check({tag, "/", vecs[i].name, "/match_cnt"},  int'(mc[i]), vecs[i].exp_match);
            check({tag, "/", vecs[i].name, "/err_cnt"},    int'(ec[i]), vecs[i].exp_err);
            check({tag, "/", vecs[i].name, "/max_err"},    int'(mx[i]), vecs[i].exp_max);
            check({tag, "/", vecs[i].name, "/hold_a"},     int'(ma[i]), 15);
            check({tag, "/", vecs[i].name, "/hold_b"},     int'(mb[i]), 15);
`ifdef MULT_SWEEP_MED_EN
            check({tag, "/", vecs[i].name, "/sum_err"},    int'(se[i]), vecs[i].exp_sum);
`endif
        end
    endtask

    initial begin
        // 4-bit operands: 256 pairs; stub 2 returns 0 so sum = (sum a)*(sum b) = 120*120.
        vecs[0] = '{"exact_l0",    0, 256,   0,   0,     0};
        vecs[1] = '{"lsb_clr_l0",  0, 192,  64,   1,    64};
        vecs[2] = '{"zero_l0",     0,  31, 225, 225, 14400};
        vecs[3] = '{"exact_l2",    2, 256,   0,   0,     0};
        vecs[4] = '{"last_bad_l1", 1, 255,   1, 225,   225};

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_sweep("run1", 1'b1);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        run_sweep("after_rst", 1'b0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        check({"abort_idle/busy"}, int'(bz[0]), 0);
        run_sweep("after_abort", 1'b0);
        run_sweep("rerun_from_done", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
